// File: rtl/debounce_pkg.sv
// Shared constants and counter sizing for the push-button/switch debouncer.
package debounce_pkg;

    localparam int DEBOUNCE_10MS_100MHZ = 1_000_000;
    localparam int HOLD_1S_100MHZ       = 100_000_000;

    // Bits needed to hold 0..max_count without wrapping; never less than 1.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, stability counter, level/strobe registers
// and an optional one-shot long-press detector.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
    parameter int HOLD_CYCLES     = HOLD_1S_100MHZ,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_hold
);

    localparam int            DW        = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [DW-1:0] dcnt;
    logic          accept;

    assign accept = (s2 != btn_level) && (dcnt == DCNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            dcnt        <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            s1          <= btn_raw ^ ACTIVE_LOW;
            s2          <= s1;
            btn_press   <= accept && s2;
            btn_release <= accept && !s2;
            if ((s2 == btn_level) || accept)
                dcnt <= '0;
            else
                dcnt <= dcnt + 1'b1;
            if (accept)
                btn_level <= s2;
        end
    end

    generate
        if (HOLD_CYCLES == 0) begin : g_no_hold
            assign btn_hold = 1'b0;
        end else begin : g_hold
            localparam int            HW        = cnt_width(HOLD_CYCLES);
            localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_CYCLES - 1);

            logic [HW-1:0] hcnt;
            logic          hold_done;
            logic          falling;

            // A release accepted on this edge beats a hold that would fire on it.
            assign falling = accept && !s2;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hcnt      <= '0;
                    hold_done <= 1'b0;
                    btn_hold  <= 1'b0;
                end else begin
                    btn_hold <= 1'b0;
                    if (!btn_level) begin
                        hcnt      <= '0;
                        hold_done <= 1'b0;
                    end else if (!hold_done && !falling) begin
                        if (hcnt == HCNT_LAST) begin
                            btn_hold  <= 1'b1;
                            hold_done <= 1'b1;
                        end else begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced inputs sitting directly behind the pad inputs.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS        = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
    parameter int HOLD_CYCLES     = HOLD_1S_100MHZ,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_hold
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i]),
            .btn_hold   (btn_hold[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Cycle-accurate check of two debounce banks (active-high and active-low pads)
// driven with mirrored inputs, so both must produce identical outputs.
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] raw;
    logic [1:0] raw_al;
    logic [1:0] lvl, prs, rel, hld;
    logic [1:0] lvl_a, prs_a, rel_a, hld_a;

    always #5 clk = ~clk;

    assign raw_al = ~raw;

    debounce_bank #(
        .CHANNELS(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw),
        .btn_level(lvl), .btn_press(prs), .btn_release(rel), .btn_hold(hld)
    );

    debounce_bank #(
        .CHANNELS(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw_al),
        .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_hold(hld_a)
    );

    typedef struct {
        string      name;
        bit         rst_n;
        bit   [1:0] raw;
        int         n;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    // Expected outputs packed as {level, press, release, hold}, bit0 = channel 0.
    function automatic logic [7:0] E(input logic [1:0] l, input logic [1:0] p,
                                     input logic [1:0] r, input logic [1:0] h);
        return {l, p, r, h};
    endfunction

    function automatic vec_t V(input string nm, input bit r, input bit [1:0] w,
                               input int n, input logic [7:0] e);
        vec_t v;
        v.name = nm; v.rst_n = r; v.raw = w; v.n = n; v.exp = e;
        return v;
    endfunction

    task automatic check_out();
        logic [7:0] e, a, b;
        string      nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {lvl, prs, rel, hld};
        b  = {lvl_a, prs_a, rel_a, hld_a};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cyc %0d high-pad bank got %b expected %b", nm, cyc, a, e);
        end
        checks++;
        if (b !== e) begin
            errors++;
            $display("FAIL %s cyc %0d low-pad bank got %b expected %b", nm, cyc, b, e);
        end
    endtask

    task automatic run(input string nm, input bit r, input bit [1:0] w,
                       input int n, input logic [7:0] e);
        for (int i = 0; i < n; i++) begin
            rst_n = r;
            raw   = w;
            exp_q.push_back(e);
            name_q.push_back(nm);
            @(posedge clk);
            #1;
            cyc++;
            check_out();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        raw   = 2'b11;

        // Reset with both pads pressed, then both accepted together.
        tbl.push_back(V("reset",       0, 2'b11,  3, E(2'b00, 2'b00, 2'b00, 2'b00)));
        tbl.push_back(V("rst_release", 1, 2'b11,  5, E(2'b00, 2'b00, 2'b00, 2'b00)));
        tbl.push_back(V("press_both",  1, 2'b11,  1, E(2'b11, 2'b11, 2'b00, 2'b00)));
        tbl.push_back(V("held_both",   1, 2'b11,  4, E(2'b11, 2'b00, 2'b00, 2'b00)));
        // ch1 released so its release lands on the edge its hold would fire.
        tbl.push_back(V("ch1_letgo",   1, 2'b01,  5, E(2'b11, 2'b00, 2'b00, 2'b00)));
        tbl.push_back(V("rel_vs_hold", 1, 2'b01,  1, E(2'b01, 2'b00, 2'b10, 2'b01)));
        tbl.push_back(V("no_2nd_hold", 1, 2'b01, 19, E(2'b01, 2'b00, 2'b00, 2'b00)));
        tbl.push_back(V("ch0_letgo",   1, 2'b00,  5, E(2'b01, 2'b00, 2'b00, 2'b00)));
        tbl.push_back(V("ch0_release", 1, 2'b00,  1, E(2'b00, 2'b00, 2'b01, 2'b00)));
        tbl.push_back(V("idle",        1, 2'b00,  3, E(2'b00, 2'b00, 2'b00, 2'b00)));
        // Bounce with 3-cycle runs, then steady press and a short hold.
        tbl.push_back(V("bounce_1",    1, 2'b01,  3, E(2'b00, 2'b00, 2'b00, 2'b00)));
        tbl.push_back(V("bounce_0",    1, 2'b00,  3, E(2'b00, 2'b00, 2'b00, 2'b00)));
        tbl.push_back(V("bounce_1",    1, 2'b01,  3, E(2'b00, 2'b00, 2'b00, 2'b00)));
        tbl.push_back(V("bounce_0",    1, 2'b00,  3, E(2'b00, 2'b00, 2'b00, 2'b00)));
        tbl.push_back(V("steady",      1, 2'b01,  5, E(2'b00, 2'b00, 2'b00, 2'b00)));
        tbl.push_back(V("steady_prs",  1, 2'b01,  1, E(2'b01, 2'b01, 2'b00, 2'b00)));
        tbl.push_back(V("short_hold",  1, 2'b00,  5, E(2'b01, 2'b00, 2'b00, 2'b00)));
        tbl.push_back(V("short_rel",   1, 2'b00,  1, E(2'b00, 2'b00, 2'b01, 2'b00)));
        tbl.push_back(V("idle",        1, 2'b00,  3, E(2'b00, 2'b00, 2'b00, 2'b00)));
        // Reset while ch0 counter is at 2: count restarts from scratch.
        tbl.push_back(V("pre_rst",     1, 2'b01,  4, E(2'b00, 2'b00, 2'b00, 2'b00)));
        tbl.push_back(V("mid_rst",     0, 2'b01,  1, E(2'b00, 2'b00, 2'b00, 2'b00)));
        tbl.push_back(V("restart",     1, 2'b01,  5, E(2'b00, 2'b00, 2'b00, 2'b00)));
        tbl.push_back(V("restart_prs", 1, 2'b01,  1, E(2'b01, 2'b01, 2'b00, 2'b00)));
        tbl.push_back(V("letgo",       1, 2'b00,  5, E(2'b01, 2'b00, 2'b00, 2'b00)));
        tbl.push_back(V("release",     1, 2'b00,  1, E(2'b00, 2'b00, 2'b01, 2'b00)));
        tbl.push_back(V("idle",        1, 2'b00,  2, E(2'b00, 2'b00, 2'b00, 2'b00)));

        foreach (tbl[i])
            run(tbl[i].name, tbl[i].rst_n, tbl[i].raw, tbl[i].n, tbl[i].exp);

        // Reset in the middle of a hold: no strobes, and the hold timer restarts.
        run("mh_wait",    1, 2'b01, 5, E(2'b00, 2'b00, 2'b00, 2'b00));
        run("mh_press",   1, 2'b01, 1, E(2'b01, 2'b01, 2'b00, 2'b00));
        run("mh_held",    1, 2'b01, 4, E(2'b01, 2'b00, 2'b00, 2'b00));
        run("mh_reset",   0, 2'b01, 1, E(2'b00, 2'b00, 2'b00, 2'b00));
        run("mh_rewait",  1, 2'b01, 5, E(2'b00, 2'b00, 2'b00, 2'b00));
        run("mh_repress", 1, 2'b01, 1, E(2'b01, 2'b01, 2'b00, 2'b00));
        run("mh_reheld",  1, 2'b01, 9, E(2'b01, 2'b00, 2'b00, 2'b00));
        run("mh_hold",    1, 2'b01, 1, E(2'b01, 2'b00, 2'b00, 2'b01));
        run("mh_after",   1, 2'b01, 5, E(2'b01, 2'b00, 2'b00, 2'b00));
        run("mh_letgo",   1, 2'b00, 5, E(2'b01, 2'b00, 2'b00, 2'b00));
        run("mh_release", 1, 2'b00, 1, E(2'b00, 2'b00, 2'b01, 2'b00));

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
